// File: rtl/lc3b_types.sv
// Shared LC-3b fetch types: machine word and the in-flight prediction record.
package lc3b_types;
  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word pred_next;
  } lc3b_fetch_entry;
endpackage

// File: rtl/pred_fifo.sv
// In-order tracker of fetched instructions and their predicted successors.
module pred_fifo
  import lc3b_types::*;
#(
  parameter int DEPTH_BITS = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  lc3b_fetch_entry din,
  output logic            full,
  output logic            empty,
  output lc3b_fetch_entry head
);
  localparam int DEPTH = 1 << DEPTH_BITS;

  lc3b_fetch_entry mem [DEPTH];
  logic [DEPTH_BITS:0] wptr, rptr;

  // Extra pointer bit distinguishes a full wrap from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[DEPTH_BITS] != rptr[DEPTH_BITS]) &&
                 (wptr[DEPTH_BITS-1:0] == rptr[DEPTH_BITS-1:0]);
  assign head  = mem[rptr[DEPTH_BITS-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wptr[DEPTH_BITS-1:0]] <= din;
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// Next-PC selection, prediction tracking, mispredict redirect and predictor update.
module fetch_pc_unit
  import lc3b_types::*;
#(
  parameter lc3b_word RESET_PC        = 16'h0000,
  parameter int       FIFO_DEPTH_BITS = 3
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     stall,
  output lc3b_word pc,
  output logic     fetch_valid,
  input  logic     pred_cf,
  input  logic     pred_take,
  input  lc3b_word pred_target,
  input  logic     res_valid,
  input  logic     res_is_cf,
  input  logic     res_is_branch,
  input  logic     res_taken,
  input  lc3b_word res_target,
  input  logic [3:0] res_op,
  output logic     redirect,
  output lc3b_word redirect_pc,
  output logic     update,
  output logic     update_is_branch,
  output lc3b_word update_pc,
  output logic     update_taken,
  output lc3b_word update_target,
  output logic [3:0] update_op,
  output lc3b_word branch_count,
  output lc3b_word mispredict_count
);
  lc3b_fetch_entry head;
  logic     full, empty, resolve;
  lc3b_word pred_next, actual_next;

  assign pred_next   = (pred_cf && pred_take) ? pred_target : pc + 16'd2;
  assign resolve     = res_valid && !empty;
  assign actual_next = (res_is_cf && res_taken) ? res_target : head.pc + 16'd2;
  assign redirect    = resolve && (actual_next != head.pred_next);
  assign redirect_pc = redirect ? actual_next : '0;
  assign fetch_valid = !stall && !full && !redirect;

  pred_fifo #(.DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fetch_valid),
    .pop     (resolve),
    .clear   (redirect),
    .din     ('{pc: pc, pred_next: pred_next}),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign update           = resolve && res_is_cf;
  assign update_pc        = update ? head.pc : '0;
  assign update_is_branch = update && res_is_branch;
  assign update_taken     = update && res_taken;
  assign update_target    = update ? res_target : '0;
  assign update_op        = update ? res_op : '0;

  // Redirect wins over stall: the corrected PC always loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc               <= RESET_PC;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (redirect)         pc <= actual_next;
      else if (fetch_valid) pc <= pred_next;
      if (update_is_branch && branch_count != 16'hFFFF)
        branch_count <= branch_count + 16'd1;
      if (redirect && mispredict_count != 16'hFFFF)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

  // Resolution with nothing in flight is an upstream protocol error.
  always_ff @(posedge clk) begin
    if (reset_n && res_valid) assert (!empty);
  end
endmodule
